// File: rtl/fpu_issue.sv
// fpu_issue: issue/retire sequencer between decode and the multi-cycle FPU.
// Accepts one decoded float op, resolves the rounding mode, runs a req/ack
// exchange with the FPU while stalling decode, then returns the result and
// accrued fflags to writeback.
// Optional build macro: FPU_TIMEOUT_EN (aborts an op when the FPU never acks).
//
// FPU handshake: fpu_req is high for every ISSUE cycle and fpu_op/fpu_a/fpu_b/
// fpu_c/fpu_rm stay stable while it is high. The FPU answers with a one-cycle
// fpu_ack pulse carrying fpu_result/fpu_flags; the exchange completes in the
// cycle ack is sampled high with req high. An ack while req is low is ignored.
module fpu_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [4:0]  dec_ALUsel,
  input  logic [2:0]  dec_rm,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rsW_float,
  input  logic        dec_csrW_en,
  input  logic [31:0] dec_opa,
  input  logic [31:0] dec_opb,
  input  logic [31:0] dec_opc,
  input  logic [2:0]  frm,
  input  logic [4:0]  fflags_in,
  output logic        stall,
  output logic        fpu_req,
  output logic [4:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  output logic [2:0]  fpu_rm,
  input  logic        fpu_ack,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_float,
  output logic [31:0] wb_data,
  output logic        fflags_we,
  output logic [4:0]  fflags_wdata,
  output logic        fault,
  output logic        fault_cause,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_FLT   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_c;
  logic [2:0]  r_rm;
  logic [4:0]  r_rd;
  logic        r_float;
  logic        r_csrw;
  logic        r_req;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic        r_fflags_we;
  logic [4:0]  r_fflags_wdata;
  logic        r_fault;

  logic [2:0]  w_rm_res;
  logic        w_rm_chk;
  logic        w_rm_bad;
  logic        w_timeout;

  // Rounding-mode resolution: dynamic rm (111) takes fcsr.frm; only ops that
  // actually round check rm, for the rest dec_rm is a sub-op selector.
  always_comb begin
    w_rm_res = (dec_rm == 3'b111) ? frm : dec_rm;
    w_rm_chk = 1'b0;
    case (dec_ALUsel)
      5'b00000, 5'b00001, 5'b00010, 5'b00011,
      5'b01011, 5'b01100, 5'b01101,
      5'b10011, 5'b10101,
      5'b11001, 5'b11011, 5'b11101, 5'b11111: w_rm_chk = 1'b1;
      default:                                 w_rm_chk = 1'b0;
    endcase
    w_rm_bad = w_rm_chk && (w_rm_res >= 3'b101);
  end

`ifdef FPU_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_fault_cause;

  // Timeout counter: zero outside ISSUE, counts ISSUE cycles without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state != S_ISSUE) begin
      r_tmo_cnt <= 8'd0;
    end else if (!fpu_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // Fires on the ISSUE cycle that would bring the count to TIMEOUT_CYCLES;
  // an ack in that same cycle wins.
  assign w_timeout   = (r_state == S_ISSUE) && !fpu_ack &&
                       ((r_tmo_cnt + 8'd1) == TIMEOUT_CYCLES[7:0]);
  assign fault_cause = r_fault_cause;
`else
  // Timeout logic is compiled out; the comparison is never true for a
  // legal parameter value and only keeps the parameter referenced.
  assign w_timeout   = (TIMEOUT_CYCLES < 0);
  assign fault_cause = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dec_valid) begin
          w_next = w_rm_bad ? S_FLT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fpu_ack) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          w_next = S_FLT;
        end
      end
      S_WB:    w_next = S_IDLE;
      S_FLT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, result capture and registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op           <= 5'd0;
      r_a            <= 32'd0;
      r_b            <= 32'd0;
      r_c            <= 32'd0;
      r_rm           <= 3'd0;
      r_rd           <= 5'd0;
      r_float        <= 1'b0;
      r_csrw         <= 1'b0;
      r_req          <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= 32'd0;
      r_fflags_we    <= 1'b0;
      r_fflags_wdata <= 5'd0;
      r_fault        <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      r_fault_cause  <= 1'b0;
`endif
    end else begin
      r_req       <= (w_next == S_ISSUE);
      r_wb_valid  <= 1'b0;
      r_fflags_we <= 1'b0;
      r_fault     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dec_valid) begin
            r_op    <= dec_ALUsel;
            r_a     <= dec_opa;
            r_b     <= dec_opb;
            r_c     <= dec_opc;
            r_rm    <= w_rm_chk ? w_rm_res : 3'b000;
            r_rd    <= dec_rd;
            r_float <= dec_rsW_float;
            r_csrw  <= dec_csrW_en;
            if (w_rm_bad) begin
              r_fault       <= 1'b1;
`ifdef FPU_TIMEOUT_EN
              r_fault_cause <= 1'b0;
`endif
            end
          end
        end
        S_ISSUE: begin
          if (fpu_ack) begin
            r_wb_valid     <= 1'b1;
            r_wb_data      <= fpu_result;
            r_fflags_we    <= r_csrw;
            r_fflags_wdata <= fflags_in | fpu_flags;
          end else if (w_timeout) begin
            r_fault       <= 1'b1;
`ifdef FPU_TIMEOUT_EN
            r_fault_cause <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = ((r_state == S_IDLE) && dec_valid) || (r_state == S_ISSUE);
  assign fpu_req      = r_req;
  assign fpu_op       = r_op;
  assign fpu_a        = r_a;
  assign fpu_b        = r_b;
  assign fpu_c        = r_c;
  assign fpu_rm       = r_rm;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_rd;
  assign wb_float     = r_float;
  assign wb_data      = r_wb_data;
  assign fflags_we    = r_fflags_we;
  assign fflags_wdata = r_fflags_wdata;
  assign fault        = r_fault;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed testbench for fpu_issue. Cycle n of an op is the cycle whose
// closing rising edge is the n-th after the edge that samples dec_valid
// (cycle 0). Inputs are driven and outputs sampled 1 ns after a rising edge.
module tb_fpu_issue;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_ALUsel;
  logic [2:0]  dec_rm;
  logic [4:0]  dec_rd;
  logic        dec_rsW_float;
  logic        dec_csrW_en;
  logic [31:0] dec_opa;
  logic [31:0] dec_opb;
  logic [31:0] dec_opc;
  logic [2:0]  frm;
  logic [4:0]  fflags_in;
  logic        stall;
  logic        fpu_req;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_c;
  logic [2:0]  fpu_rm;
  logic        fpu_ack;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_float;
  logic [31:0] wb_data;
  logic        fflags_we;
  logic [4:0]  fflags_wdata;
  logic        fault;
  logic        fault_cause;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  logic [14:0] rm_tbl [8];

  fpu_issue #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ALUsel(dec_ALUsel), .dec_rm(dec_rm),
    .dec_rd(dec_rd), .dec_rsW_float(dec_rsW_float), .dec_csrW_en(dec_csrW_en),
    .dec_opa(dec_opa), .dec_opb(dec_opb), .dec_opc(dec_opc),
    .frm(frm), .fflags_in(fflags_in),
    .stall(stall), .fpu_req(fpu_req), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_rm(fpu_rm),
    .fpu_ack(fpu_ack), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_float(wb_float), .wb_data(wb_data),
    .fflags_we(fflags_we), .fflags_wdata(fflags_wdata),
    .fault(fault), .fault_cause(fault_cause), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    dec_valid     = 1'b0;
    dec_ALUsel    = 5'd0;
    dec_rm        = 3'd0;
    dec_rd        = 5'd0;
    dec_rsW_float = 1'b0;
    dec_csrW_en   = 1'b0;
    dec_opa       = 32'd0;
    dec_opb       = 32'd0;
    dec_opc       = 32'd0;
    frm           = 3'd0;
    fflags_in     = 5'd0;
    fpu_ack       = 1'b0;
    fpu_result    = 32'd0;
    fpu_flags     = 5'd0;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [2:0] rm,
                          input logic [4:0] rd, input logic fl, input logic csrw,
                          input logic [31:0] a, input logic [31:0] b);
    dec_valid     = 1'b1;
    dec_ALUsel    = op;
    dec_rm        = rm;
    dec_rd        = rd;
    dec_rsW_float = fl;
    dec_csrW_en   = csrw;
    dec_opa       = a;
    dec_opb       = b;
    dec_opc       = a ^ b;
  endtask

  // Scenarios
  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({fpu_req, stall, wb_valid, fault, fflags_we, fault_cause} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {fpu_req, stall, wb_valid, fault, fflags_we, fault_cause});
    end
    n_checks++;
    if ({wb_data, fpu_a, fpu_op, fpu_rm, fflags_wdata, wb_rd} !== 82'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {wb_data, fpu_a, fpu_op, fpu_rm, fflags_wdata, wb_rd});
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fadd;
    drive_op(5'b00000, 3'b000, 5'd3, 1'b1, 1'b1, 32'h3f800000, 32'h40000000);
    fflags_in = 5'b10000;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL fadd_stall_c0: got %b want 1", stall);
    end
    tick(); // cycle 1
    dec_valid = 1'b0;
    n_checks++;
    if (fpu_req !== 1'b1) begin
      n_fail++; $display("FAIL fadd_req_c1: got %b want 1", fpu_req);
    end
    n_checks++;
    if ({fpu_op, fpu_rm, fpu_a, fpu_b, fpu_c} !== {5'b00000, 3'b000, 32'h3f800000, 32'h40000000, 32'h7f800000}) begin
      n_fail++;
      $display("FAIL fadd_operands: got %h %h %h %h %h want 00 0 3f800000 40000000 7f800000",
               fpu_op, fpu_rm, fpu_a, fpu_b, fpu_c);
    end
    fpu_ack = 1'b1; fpu_result = 32'h40400000; fpu_flags = 5'b00001;
    tick(); // cycle 2
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, fflags_we, wb_float, stall, fpu_req} !== 5'b11100) begin
      n_fail++;
      $display("FAIL fadd_wb_ctrl: got %b want 11100", {wb_valid, fflags_we, wb_float, stall, fpu_req});
    end
    n_checks++;
    if (wb_data !== 32'h40400000) begin
      n_fail++; $display("FAIL fadd_wb_data: got %h want 40400000", wb_data);
    end
    n_checks++;
    if ({wb_rd, fflags_wdata} !== {5'd3, 5'b10001}) begin
      n_fail++; $display("FAIL fadd_rd_flags: got %0d %b want 3 10001", wb_rd, fflags_wdata);
    end
    tick(); // cycle 3
    n_checks++;
    if ({wb_valid, fflags_we} !== 2'b00) begin
      n_fail++; $display("FAIL fadd_wb_pulse: got %b want 00", {wb_valid, fflags_we});
    end
    fflags_in = 5'd0;
  endtask

  task automatic test_fdiv_dyn_rm;
    drive_op(5'b00011, 3'b111, 5'd9, 1'b1, 1'b0, 32'h41200000, 32'h40000000);
    frm = 3'b010;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL fdiv_stall_c0: got %b want 1", stall);
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (cyc == 1) begin
        n_checks++;
        if (fpu_rm !== 3'b010) begin
          n_fail++; $display("FAIL fdiv_rm: got %b want 010", fpu_rm);
        end
        dec_opa = 32'hdeadbeef; // decode changes under stall: must be ignored
      end
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++; $display("FAIL fdiv_stall_c%0d: got %b want 1", cyc, stall);
      end
      if (cyc == 20) begin
        n_checks++;
        if ({fpu_req, fpu_a} !== {1'b1, 32'h41200000}) begin
          n_fail++; $display("FAIL fdiv_hold: got %b %h want 1 41200000", fpu_req, fpu_a);
        end
        fpu_ack = 1'b1; fpu_result = 32'h40a00000; fpu_flags = 5'b00001;
      end
    end
    tick(); // cycle 21, dec_valid still high but WB ignores it
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, stall, fflags_we, wb_float} !== 4'b1001) begin
      n_fail++; $display("FAIL fdiv_wb: got %b want 1001", {wb_valid, stall, fflags_we, wb_float});
    end
    n_checks++;
    if ({wb_data, wb_rd} !== {32'h40a00000, 5'd9}) begin
      n_fail++; $display("FAIL fdiv_wb_data: got %h %0d want 40a00000 9", wb_data, wb_rd);
    end
    dec_valid = 1'b0;
    frm = 3'b000;
    tick();
  endtask

  task automatic test_illegal_rm;
    logic seen;
    seen = 1'b0;
    drive_op(5'b00000, 3'b101, 5'd6, 1'b1, 1'b1, 32'h1, 32'h2);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL ill_stall_c0: got %b want 1", stall);
    end
    tick(); // cycle 1
    dec_valid = 1'b0;
    n_checks++;
    if ({fault, fault_cause, stall} !== 3'b100) begin
      n_fail++; $display("FAIL ill_fault_c1: got %b want 100", {fault, fault_cause, stall});
    end
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (fpu_req || wb_valid || fflags_we) seen = 1'b1;
      if (cyc < 4) tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL ill_no_side_effects: got %b want 0", seen);
    end
    n_checks++;
    if ({fault, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL ill_back_idle: got %b want 000", {fault, dbg_state});
    end
  endtask

  task automatic test_rm_table;
    // {ALUsel, dec_rm, frm, expect fault, expected fpu_rm}
    rm_tbl = '{
      {5'b00000, 3'b100, 3'b000, 1'b0, 3'b100},
      {5'b11001, 3'b110, 3'b000, 1'b1, 3'b000},
      {5'b10001, 3'b111, 3'b111, 1'b0, 3'b000},
      {5'b01011, 3'b111, 3'b101, 1'b1, 3'b000},
      {5'b10101, 3'b111, 3'b001, 1'b0, 3'b001},
      {5'b00100, 3'b101, 3'b000, 1'b0, 3'b000},
      {5'b11111, 3'b111, 3'b110, 1'b1, 3'b000},
      {5'b01101, 3'b011, 3'b000, 1'b0, 3'b011}
    };
    for (int i = 0; i < 8; i++) begin
      logic [14:0] e;
      e = rm_tbl[i];
      drive_op(e[14:10], e[9:7], 5'(i + 1), 1'b1, 1'b0, 32'(i), 32'(i * 3));
      frm = e[6:4];
      tick(); // cycle 1
      dec_valid = 1'b0;
      if (e[3]) begin
        n_checks++;
        if ({fault, fault_cause, fpu_req} !== 3'b100) begin
          n_fail++; $display("FAIL rm_tbl%0d_fault: got %b want 100", i, {fault, fault_cause, fpu_req});
        end
        tick();
      end else begin
        n_checks++;
        if ({fault, fpu_req, fpu_rm} !== {2'b01, e[2:0]}) begin
          n_fail++; $display("FAIL rm_tbl%0d_issue: got %b want %b", i, {fault, fpu_req, fpu_rm}, {2'b01, e[2:0]});
        end
        fpu_ack = 1'b1; fpu_result = 32'(100 + i);
        tick();
        fpu_ack = 1'b0;
        n_checks++;
        if ({wb_valid, wb_data} !== {1'b1, 32'(100 + i)}) begin
          n_fail++; $display("FAIL rm_tbl%0d_wb: got %b %h want 1 %h", i, wb_valid, wb_data, 32'(100 + i));
        end
        tick();
      end
    end
    frm = 3'b000;
  endtask

  task automatic test_feq_int;
    drive_op(5'b10000, 3'b010, 5'd7, 1'b0, 1'b1, 32'h3f800000, 32'h3f800000);
    fflags_in = 5'b00001;
    tick(); // cycle 1
    dec_valid = 1'b0;
    n_checks++;
    if ({fpu_req, fpu_op, fpu_rm, fault} !== {1'b1, 5'b10000, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL feq_issue: got %b %b %b %b want 1 10000 000 0", fpu_req, fpu_op, fpu_rm, fault);
    end
    fpu_ack = 1'b1; fpu_result = 32'h1; fpu_flags = 5'b10000;
    tick(); // cycle 2
    fpu_ack = 1'b0; fpu_flags = 5'd0;
    n_checks++;
    if ({wb_valid, wb_float, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd7, 32'h1}) begin
      n_fail++; $display("FAIL feq_wb: got %b %b %0d %h want 1 0 7 1", wb_valid, wb_float, wb_rd, wb_data);
    end
    n_checks++;
    if ({fflags_we, fflags_wdata} !== {1'b1, 5'b10001}) begin
      n_fail++; $display("FAIL feq_flags: got %b %b want 1 10001", fflags_we, fflags_wdata);
    end
    fflags_in = 5'd0;
    tick();
  endtask

  task automatic test_back_to_back;
    drive_op(5'b00001, 3'b001, 5'd4, 1'b1, 1'b1, 32'h11111111, 32'h1);
    fflags_in = 5'b00100;
    tick(); // cycle 1: A in ISSUE, decode already presents B
    drive_op(5'b00010, 3'b000, 5'd5, 1'b1, 1'b1, 32'h22222222, 32'h2);
    n_checks++;
    if ({fpu_req, fpu_a} !== {1'b1, 32'h11111111}) begin
      n_fail++; $display("FAIL b2b_a_issue: got %b %h want 1 11111111", fpu_req, fpu_a);
    end
    fpu_ack = 1'b1; fpu_result = 32'haaaa0000; fpu_flags = 5'b01000;
    tick(); // cycle 2: WB of A
    fpu_ack = 1'b0; fpu_flags = 5'd0;
    n_checks++;
    if ({wb_valid, stall, fflags_wdata, wb_data} !== {1'b1, 1'b0, 5'b01100, 32'haaaa0000}) begin
      n_fail++; $display("FAIL b2b_a_wb: got %b %b %b %h want 1 0 01100 aaaa0000", wb_valid, stall, fflags_wdata, wb_data);
    end
    tick(); // cycle 3: IDLE, B sampled
    n_checks++;
    if ({fpu_req, wb_valid, stall, dbg_state} !== 5'b00100) begin
      n_fail++; $display("FAIL b2b_idle: got %b want 00100", {fpu_req, wb_valid, stall, dbg_state});
    end
    tick(); // cycle 4: B in ISSUE
    dec_valid = 1'b0;
    n_checks++;
    if ({fpu_req, fpu_op, fpu_a} !== {1'b1, 5'b00010, 32'h22222222}) begin
      n_fail++; $display("FAIL b2b_b_issue: got %b %b %h want 1 00010 22222222", fpu_req, fpu_op, fpu_a);
    end
    fpu_ack = 1'b1; fpu_result = 32'hbbbb0000;
    tick(); // cycle 5
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hbbbb0000}) begin
      n_fail++; $display("FAIL b2b_b_wb: got %b %0d %h want 1 5 bbbb0000", wb_valid, wb_rd, wb_data);
    end
    fflags_in = 5'd0;
    tick();
  endtask

  task automatic test_reset_mid_op;
    drive_op(5'b00000, 3'b000, 5'd2, 1'b1, 1'b1, 32'h33333333, 32'h4);
    tick(); // cycle 1
    dec_valid = 1'b0;
    tick(); // cycle 2, still ISSUE
    n_checks++;
    if (fpu_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_req_before: got %b want 1", fpu_req);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fpu_req, stall, wb_valid, dbg_state} !== 5'b00000) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 00000", {fpu_req, stall, wb_valid, dbg_state});
    end
    fpu_ack = 1'b1; fpu_result = 32'hffffffff; fpu_flags = 5'b11111;
    @(posedge clk);
    #1;
    fpu_ack = 1'b0; fpu_flags = 5'd0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({wb_valid, fflags_we, fflags_wdata} !== 7'd0) begin
      n_fail++; $display("FAIL rstmid_no_wb: got %b want 0000000", {wb_valid, fflags_we, fflags_wdata});
    end
    // Stray ack while idle
    fpu_ack = 1'b1;
    tick();
    fpu_ack = 1'b0;
    tick();
    n_checks++;
    if ({wb_valid, fpu_req, dbg_state} !== 4'b0000) begin
      n_fail++; $display("FAIL stray_ack: got %b want 0000", {wb_valid, fpu_req, dbg_state});
    end
    // Fresh op after reset
    drive_op(5'b00010, 3'b011, 5'd12, 1'b1, 1'b1, 32'h44444444, 32'h5);
    tick();
    dec_valid = 1'b0;
    n_checks++;
    if ({fpu_req, fpu_rm, fpu_a} !== {1'b1, 3'b011, 32'h44444444}) begin
      n_fail++; $display("FAIL rstmid_reissue: got %b %b %h want 1 011 44444444", fpu_req, fpu_rm, fpu_a);
    end
    fpu_ack = 1'b1; fpu_result = 32'h55555555;
    tick();
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd12, 32'h55555555}) begin
      n_fail++; $display("FAIL rstmid_wb: got %b %0d %h want 1 12 55555555", wb_valid, wb_rd, wb_data);
    end
    tick();
  endtask

`ifdef FPU_TIMEOUT_EN
  task automatic test_timeout;
    drive_op(5'b00011, 3'b000, 5'd8, 1'b1, 1'b1, 32'h66666666, 32'h7);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      dec_valid = 1'b0;
      n_checks++;
      if ({fpu_req, fault} !== 2'b10) begin
        n_fail++; $display("FAIL tmo_req_c%0d: got %b want 10", cyc, {fpu_req, fault});
      end
    end
    tick(); // cycle 5: FLT
    n_checks++;
    if ({fpu_req, fault, fault_cause, stall} !== 4'b0110) begin
      n_fail++; $display("FAIL tmo_fault: got %b want 0110", {fpu_req, fault, fault_cause, stall});
    end
    fpu_ack = 1'b1; // late ack
    tick();
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, fflags_we, fault, dbg_state} !== 5'b00000) begin
      n_fail++; $display("FAIL tmo_late_ack: got %b want 00000", {wb_valid, fflags_we, fault, dbg_state});
    end
    // Ack on the timeout cycle wins
    drive_op(5'b00011, 3'b000, 5'd8, 1'b1, 1'b1, 32'h77777777, 32'h7);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      dec_valid = 1'b0;
    end
    fpu_ack = 1'b1; fpu_result = 32'h12345678;
    tick();
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, fault, wb_data} !== {2'b10, 32'h12345678}) begin
      n_fail++; $display("FAIL tmo_ack_priority: got %b %b %h want 1 0 12345678", wb_valid, fault, wb_data);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout;
    logic seen_fault;
    logic req_low;
    seen_fault = 1'b0;
    req_low    = 1'b0;
    drive_op(5'b00011, 3'b000, 5'd8, 1'b1, 1'b1, 32'h66666666, 32'h7);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      dec_valid = 1'b0;
      if (fault) seen_fault = 1'b1;
      if (!fpu_req) req_low = 1'b1;
    end
    n_checks++;
    if ({seen_fault, req_low, fault_cause} !== 3'b000) begin
      n_fail++; $display("FAIL notmo_wait: got %b want 000", {seen_fault, req_low, fault_cause});
    end
    fpu_ack = 1'b1; fpu_result = 32'h12345678;
    tick();
    fpu_ack = 1'b0;
    n_checks++;
    if ({wb_valid, wb_data} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL notmo_wb: got %b %h want 1 12345678", wb_valid, wb_data);
    end
    tick();
  endtask
`endif

  // Sequencer and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_fadd();
    test_fdiv_dyn_rm();
    test_illegal_rm();
    test_rm_table();
    test_feq_int();
    test_back_to_back();
    test_reset_mid_op();
`ifdef FPU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
